// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// reset PC default, flush NOP and the redirect alignment helper.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        FC_IDLE = 2'd0,
        FC_RUN  = 2'd1,
        FC_HALT = 2'd2
    } fc_state_t;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;

    // Redirect targets are forced onto a word boundary; the low bits only feed the error flag.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// ROM address/data bus and IF/ID pipeline register outputs of the fetch stage.
interface fetch_ctrl_if;

    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;
    logic        id_valid;

    modport master (
        output rom_addr,
        output id_inst,
        output id_pc4,
        output id_valid,
        input  rom_inst
    );

    modport slave (
        input  rom_addr,
        input  id_inst,
        input  id_pc4,
        input  id_valid,
        output rom_inst
    );

endinterface

// File: rtl/fetch_ctrl_if_id.sv
// IF/ID pipeline register: flush inserts a NOP bubble, load captures a new
// instruction, otherwise the contents hold.
module if_id_reg
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] inst_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] inst,
    output logic [31:0] pc4,
    output logic        valid
);

    // Flush wins over load so a wrong-path word can never be captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst  <= NOP_INST;
            pc4   <= 32'h0;
            valid <= 1'b0;
        end else if (flush) begin
            inst  <= NOP_INST;
            valid <= 1'b0;
        end else if (load) begin
            inst  <= inst_in;
            pc4   <= pc4_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address and feeds
// the IF/ID register under stall, redirect and run/halt control.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    fetch_ctrl_if.master     bus,
    output logic             running,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_cnt
);

    fc_state_t   state;
    fc_state_t   state_nxt;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        load;
    logic        flush;

    assign pc4          = pc + 32'd4;
    assign bus.rom_addr = pc;
    assign running      = (state == FC_RUN);

    // Redirect overrides stall; outside RUN the IF/ID register only ever sees bubbles.
    assign load  = (state == FC_RUN) && !redirect_valid && !stall;
    assign flush = (state != FC_RUN) || redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A halt request beats a simultaneous start; start in RUN is a no-op.
    always_comb begin
        state_nxt = state;
        case (state)
            FC_IDLE: if (start && !halt_req) state_nxt = FC_RUN;
            FC_RUN:  if (halt_req)           state_nxt = FC_HALT;
            FC_HALT: if (start && !halt_req) state_nxt = FC_RUN;
            default:                         state_nxt = FC_IDLE;
        endcase
    end

    // Redirects update the PC in every state so software can preload the start address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= PC_RESET;
            misalign_err <= 1'b0;
            fetch_cnt    <= '0;
        end else begin
            if (redirect_valid) begin
                pc <= align_pc(redirect_pc);
                if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
            end else if (load) begin
                pc <= pc4;
            end
            if (load && (fetch_cnt != '1)) begin
                fetch_cnt <= fetch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    if_id_reg u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .flush   (flush),
        .inst_in (bus.rom_inst),
        .pc4_in  (pc4),
        .inst    (bus.id_inst),
        .pc4     (bus.id_pc4),
        .valid   (bus.id_valid)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random
// control traffic, all compared against a behavioural model of the fetch rules.
module tb_fetch_ctrl;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        running;
    logic        misalign_err;
    logic [15:0] fetch_cnt;
    logic        running_s;
    logic        misalign_err_s;
    logic [3:0]  fetch_cnt_s;

    int checks   = 0;
    int failures = 0;

    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_err;
    int          m_cnt;

    always #5 clk = ~clk;

    fetch_ctrl_if bus ();
    fetch_ctrl_if bus_s ();

    // ROM model: every word encodes its own byte address.
    assign bus.rom_inst   = 32'hA000_0000 | bus.rom_addr;
    assign bus_s.rom_inst = 32'hA000_0000 | bus_s.rom_addr;

    fetch_ctrl #(.PC_RESET(32'h0000_0000), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt_req       (halt_req),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus.master),
        .running        (running),
        .misalign_err   (misalign_err),
        .fetch_cnt      (fetch_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, so saturation is reached quickly.
    fetch_ctrl #(.PC_RESET(32'h0000_0000), .CNT_W(4)) dut_sat (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt_req       (halt_req),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus_s.master),
        .running        (running_s),
        .misalign_err   (misalign_err_s),
        .fetch_cnt      (fetch_cnt_s)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_mode  = M_IDLE;
        m_pc    = 32'h0;
        m_inst  = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    // One clock edge of the fetch rules, using the inputs present at that edge.
    task automatic modelStep();
        int nxt;
        nxt = m_mode;
        if (m_mode == M_RUN) begin
            if (redirect_valid) begin
                m_pc    = redirect_pc & 32'hFFFF_FFFC;
                m_valid = 1'b0;
                m_inst  = 32'h0;
                if (redirect_pc[1:0] != 2'b00) m_err = 1'b1;
            end else if (!stall) begin
                m_inst  = 32'hA000_0000 | m_pc;
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
                if (m_cnt < 65535) m_cnt++;
            end
            if (halt_req) nxt = M_HALT;
        end else begin
            m_valid = 1'b0;
            m_inst  = 32'h0;
            if (redirect_valid) begin
                m_pc = redirect_pc & 32'hFFFF_FFFC;
                if (redirect_pc[1:0] != 2'b00) m_err = 1'b1;
            end
            if (start && !halt_req) nxt = M_RUN;
        end
        m_mode = nxt;
    endtask

    task automatic checkAll(input string phase);
        checkOutput({phase, ":rom_addr"},  bus.rom_addr, m_pc);
        checkOutput({phase, ":id_inst"},   bus.id_inst,  m_inst);
        checkOutput({phase, ":id_pc4"},    bus.id_pc4,   m_pc4);
        checkOutput({phase, ":id_valid"},  {31'b0, bus.id_valid}, {31'b0, m_valid});
        checkOutput({phase, ":running"},   {31'b0, running}, {31'b0, (m_mode == M_RUN)});
        checkOutput({phase, ":misalign"},  {31'b0, misalign_err}, {31'b0, m_err});
        checkOutput({phase, ":fetch_cnt"}, {16'b0, fetch_cnt}, m_cnt);
        checkOutput({phase, ":sat_cnt"},   {28'b0, fetch_cnt_s}, (m_cnt > 15) ? 15 : m_cnt);
        checkOutput({phase, ":sat_addr"},  bus_s.rom_addr, m_pc);
        checkOutput({phase, ":sat_valid"}, {31'b0, bus_s.id_valid}, {31'b0, m_valid});
    endtask

    task automatic applyStimulus(input logic s, input logic h, input logic st, input logic rv,
                                 input logic [31:0] rp, input string phase);
        @(negedge clk);
        start          = s;
        halt_req       = h;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rp;
        @(posedge clk);
        modelStep();
        #1;
        checkAll(phase);
    endtask

    task automatic asyncReset();
        @(negedge clk);
        start          = 1'b0;
        halt_req       = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk);
        modelStep();
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic        s, h, st, rv;
        logic [31:0] rp;

        rst_n          = 1'b1;
        start          = 1'b0;
        halt_req       = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1 rst_n = 1'b0;
        #11;
        modelReset();
        checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "start");
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "fetch");
        checkOutput("pre_stall_inst", bus.id_inst, 32'hA000_0004);
        checkOutput("pre_stall_pc", bus.rom_addr, 32'h0000_0008);

        repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "stall");
        checkOutput("stall_pc_frozen", bus.rom_addr, 32'h0000_0008);
        checkOutput("stall_inst_frozen", bus.id_inst, 32'hA000_0004);
        checkOutput("stall_cnt_frozen", {16'b0, fetch_cnt}, 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "resume");
        checkOutput("resume_inst", bus.id_inst, 32'hA000_0008);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h14, "redir_stall");
        checkOutput("redir_flush_valid", {31'b0, bus.id_valid}, 32'd0);
        checkOutput("redir_pc", bus.rom_addr, 32'h0000_0014);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "after_redir");
        checkOutput("redir_capture_inst", bus.id_inst, 32'hA000_0014);
        checkOutput("redir_capture_pc4", bus.id_pc4, 32'h0000_0018);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h13, "misalign");
        checkOutput("misalign_pc", bus.rom_addr, 32'h0000_0010);
        checkOutput("misalign_flag", {31'b0, misalign_err}, 32'd1);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h4, "set_pc4");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "halt_edge");
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "halted");
        checkOutput("halt_pc_hold", bus.rom_addr, 32'h0000_0008);
        checkOutput("halt_valid_low", {31'b0, bus.id_valid}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "restart");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "first_after_restart");
        checkOutput("resume_fetch_0x8", bus.id_inst, 32'hA000_0008);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, "halt_start_run");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, "halt_start_halt");
        checkOutput("halt_wins", {31'b0, running}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "restart2");

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, "to_top");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "wrap");
        checkOutput("wrap_pc", bus.rom_addr, 32'h0000_0000);
        checkOutput("wrap_pc4", bus.id_pc4, 32'h0000_0000);
        checkOutput("misalign_sticky", {31'b0, misalign_err}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "post_wrap");
        asyncReset();

        for (int i = 0; i < 600; i++) begin
            s  = ($urandom_range(0, 9) == 0);
            h  = ($urandom_range(0, 24) == 0);
            if (m_mode == M_IDLE && s && h) h = 1'b0;
            st = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       rp = $urandom & 32'h0000_00FC;
                1:       rp = $urandom;
                2:       rp = 32'hFFFF_FFFC;
                default: rp = 32'h0000_0013;
            endcase
            if ($urandom_range(0, 249) == 0) begin
                asyncReset();
            end else begin
                applyStimulus(s, h, st, rv, rp, "rand");
            end
        end

        if (m_cnt > 15) checkOutput("sat_at_max", {28'b0, fetch_cnt_s}, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the five-stage pipeline.
- Owns the PC and drives the combinational instruction ROM address. Captures the returned word into the IF/ID pipeline register.
- Applies stall, redirect (branch/jump) and run/halt control from the hazard unit and the ID/EX stages.
- Sits between the instruction ROM and the decode stage.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the delivered-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begin or resume fetching from current PC.
- halt_req  in  1  pulse; stop fetching after the current cycle.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- redirect_valid  in  1  take redirect_pc next cycle (taken beq / jump).
- redirect_pc  in  32  byte-address target.
- rom_addr  out  32  byte address to the ROM (ROM indexes bits [7:2]).
- rom_inst  in  32  combinational ROM data for rom_addr.
- id_inst  out  32  IF/ID instruction.
- id_pc4  out  32  IF/ID PC+4 of id_inst.
- id_valid  out  1  IF/ID holds a real instruction.
- running  out  1  state == RUN.
- misalign_err  out  1  sticky; a redirect target had bits [1:0] != 0.
- fetch_cnt  out  CNT_W  instructions delivered to IF/ID, saturating.

Behaviour:
- Reset (async, rst_n=0) sets these values:
  - pc=PC_RESET and state=IDLE.
  - id_inst=0, id_pc4=0, id_valid=0.
  - misalign_err=0, fetch_cnt=0, running=0.
- rom_addr = pc, combinationally. The ROM is zero-latency, so an instruction is captured on the edge after its address is driven.
- States:
  - IDLE: no fetch. Next state RUN on start.
  - RUN: fetch every non-stalled cycle. Next state HALT on halt_req.
  - HALT: no fetch, PC preserved. Next state RUN on start.
  - halt_req and start in the same cycle: halt_req wins.
  - start while in RUN and halt_req in IDLE are ignored.
- RUN cycle priority (highest first):
  1. redirect_valid:
     - pc <= {redirect_pc[31:2],2'b00}; id_valid<=0; id_inst<=0 (flush the wrong-path fetch).
     - misalign_err<=1 if redirect_pc[1:0]!=0.
     - Redirect overrides a simultaneous stall.
  2. stall: pc, id_inst, id_pc4 and id_valid all hold.
  3. advance:
     - id_inst<=rom_inst; id_pc4<=pc+4; id_valid<=1; pc<=pc+4.
     - fetch_cnt increments, saturating at all-ones.
- IDLE/HALT cycles:
  - id_valid<=0, id_inst<=0.
  - redirect_valid still updates pc (and misalign_err), so software can set the start PC before start.
  - stall is ignored.
- Transition cycles:
  - Entering HALT: on the halt_req edge the normal RUN action still occurs. id_valid drops on the following edge.
  - Leaving IDLE/HALT on start: the first fetch occurs on the edge after the start edge.
- PC arithmetic is 32-bit modulo 2^32. 0xFFFF_FFFC+4 wraps to 0. ROM aliasing above 0xFC is the ROM's concern.
- Async reset mid-operation aborts immediately; no partial IF/ID update survives.
- All outputs are registered except rom_addr (equals the pc register).

Decomposition:
- Shared pipeline package:
  - state encoding constants FC_IDLE=2'd0, FC_RUN=2'd1, FC_HALT=2'd2;
  - PC_RESET default;
  - the NOP encoding 32'h0 used for flush.
- One sub-module: if_id_reg (IF/ID register with load/hold/flush controls). The PC and FSM stay in fetch_ctrl.

Test Plan:
- Bench ROM returns 32'hA000_0000|addr.
  - Stimulus: reset, start, run 4 cycles.
  - Required: rom_addr 0x0,0x4,0x8,0xC; id_inst 0xA0000000,0xA0000004,…; id_pc4 0x4,0x8,…; fetch_cnt=4.
- Stall:
  - Stimulus: hold stall high 2 cycles at pc=0x8.
  - Required: pc, id_inst=0xA0000004 and id_valid stay frozen; fetch resumes at 0x8; fetch_cnt does not increment during stall.
- Redirect with simultaneous stall:
  - Stimulus: redirect_valid=1, stall=1, redirect_pc=0x14.
  - Required: next cycle id_valid=0, id_inst=0, pc=0x14; following capture id_inst=0xA0000014, id_pc4=0x18.
- Misaligned redirect:
  - Stimulus: redirect_pc=0x13.
  - Required: pc=0x10; misalign_err=1 and it stays 1 until rst_n.
- Halt and resume:
  - Stimulus: halt_req at pc=0x8, then start 3 cycles later.
  - Required: id_valid=0 while halted; pc holds 0x8; resume fetches 0x8; halt_req+start together → HALT.
- Reset and wrap:
  - Stimulus 1: assert rst_n=0 mid-RUN asynchronously (between edges).
    - Required: outputs go to reset values immediately.
  - Stimulus 2: redirect to 0xFFFFFFFC in RUN.
    - Required: pc wraps to 0x0 after one fetch.
  - Stimulus 3: fetch_cnt preset near saturation via forced run.
    - Required: fetch_cnt saturates at 0xFFFF.
